// File: rtl/hazard_scoreboard_unit_if.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard_unit_if
//   Signals between the ID/EX control path and the hazard/forwarding unit.
//   The master modport belongs to the pipeline, which drives the hazard
//   inputs. The slave modport belongs to the hazard unit, which returns the
//   forward selects, the stall/bubble controls and the scoreboard status.
//
//   Inputs to the hazard unit:
//     id_rs1/id_rs2, id_use_rs1/id_use_rs2, id_branch  : instruction in IF_ID
//     ex_rs1/ex_rs2, ex_rd, ex_regWrite, ex_load        : instruction in ID_EX
//     stage_rd, stage_regWrite, stage0_load             : forwarding stages
//     mc_issue, mc_rd, mc_latency                       : multi-cycle issue
//   Outputs from the hazard unit:
//     forwardOp1/2, ID_forwardOp1/2                     : operand selects
//     stall, nop                                        : hold and bubble
//     mc_busy, mc_done, mc_done_rd                      : scoreboard status
//
//   Handshake: none. Every signal is level-sampled once per clock cycle.
//   mc_issue is taken at the clock edge only when stall is low in that same
//   cycle. mc_done is a single-cycle pulse, and mc_done_rd qualifies it.
// ----------------------------------------------------------------------------
interface hazard_scoreboard_unit_if #(
    parameter int REG_AW     = 5,
    parameter int FWD_STAGES = 2,
    parameter int MC_LAT_W   = 4
);
    localparam int SEL_W = $clog2(FWD_STAGES + 1);

    logic [REG_AW-1:0]            id_rs1;
    logic [REG_AW-1:0]            id_rs2;
    logic                         id_use_rs1;
    logic                         id_use_rs2;
    logic                         id_branch;
    logic [REG_AW-1:0]            ex_rs1;
    logic [REG_AW-1:0]            ex_rs2;
    logic [REG_AW-1:0]            ex_rd;
    logic                         ex_regWrite;
    logic                         ex_load;
    logic [FWD_STAGES*REG_AW-1:0] stage_rd;
    logic [FWD_STAGES-1:0]        stage_regWrite;
    logic                         stage0_load;
    logic                         mc_issue;
    logic [REG_AW-1:0]            mc_rd;
    logic [MC_LAT_W-1:0]          mc_latency;

    logic [SEL_W-1:0]             forwardOp1;
    logic [SEL_W-1:0]             forwardOp2;
    logic [SEL_W-1:0]             ID_forwardOp1;
    logic [SEL_W-1:0]             ID_forwardOp2;
    logic                         stall;
    logic                         nop;
    logic                         mc_busy;
    logic                         mc_done;
    logic [REG_AW-1:0]            mc_done_rd;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_branch,
               ex_rs1, ex_rs2, ex_rd, ex_regWrite, ex_load,
               stage_rd, stage_regWrite, stage0_load,
               mc_issue, mc_rd, mc_latency,
        input  forwardOp1, forwardOp2, ID_forwardOp1, ID_forwardOp2,
               stall, nop, mc_busy, mc_done, mc_done_rd
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_branch,
               ex_rs1, ex_rs2, ex_rd, ex_regWrite, ex_load,
               stage_rd, stage_regWrite, stage0_load,
               mc_issue, mc_rd, mc_latency,
        output forwardOp1, forwardOp2, ID_forwardOp1, ID_forwardOp2,
               stall, nop, mc_busy, mc_done, mc_done_rd
    );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard_unit
//   Hazard and forwarding unit for the 5-stage RISC-V pipeline.
//   - Combinational forward selects for the EX operands and for the ID-stage
//     branch/jalr operands. The youngest matching stage wins.
//   - Stall (and the equal nop bubble) is raised for:
//       load-use,
//       a branch that depends on ID_EX or on a load in EX_MEM,
//       a read of a register still pending in the multi-cycle scoreboard,
//       a multi-cycle issue when every slot is full or its rd is already
//       pending (WAW).
//   - The scoreboard has MC_SLOTS slots. Each slot counts down the latency of
//     one outstanding mul/div op and reports completion with mc_done.
//
//   Ports:
//     clock  rising-edge clock
//     reset  asynchronous, active-low
//     hz     hazard_scoreboard_unit_if.slave (signal list is in the interface)
//
//   Optional feature: macro HAZARD_PERF_EN adds two output ports.
//     perf_stall_cycles  saturating count of cycles with stall = 1
//     perf_mc_stalls     saturating count of cycles stalled by the scoreboard
// ----------------------------------------------------------------------------
module hazard_scoreboard_unit #(
    parameter int REG_AW     = 5,
    parameter int FWD_STAGES = 2,
    parameter int MC_SLOTS   = 2,
    parameter int MC_LAT_W   = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    hazard_scoreboard_unit_if.slave hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]             perf_stall_cycles,
    output logic [31:0]             perf_mc_stalls
`endif
);
    localparam int SEL_W = $clog2(FWD_STAGES + 1);

    // True when r is a real register that the ID instruction actually reads.
    function automatic logic reads_reg(input logic [REG_AW-1:0] r,
                                       input logic [REG_AW-1:0] rs1,
                                       input logic [REG_AW-1:0] rs2,
                                       input logic u1,
                                       input logic u2);
        return (r != '0) && ((u1 && (rs1 == r)) || (u2 && (rs2 == r)));
    endfunction

    logic [REG_AW-1:0] stage_rd [FWD_STAGES];
    for (genvar k = 0; k < FWD_STAGES; k++) begin : g_unpack
        assign stage_rd[k] = hz.stage_rd[k*REG_AW +: REG_AW];
    end

    // ---------------- forwarding ----------------
    logic [SEL_W-1:0] fwd1, fwd2, idf1, idf2;

    always_comb begin
        fwd1 = '0;
        fwd2 = '0;
        idf1 = '0;
        idf2 = '0;
        // Walk from the oldest stage to the youngest, so the youngest match
        // is written last and wins.
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (hz.stage_regWrite[k] && (stage_rd[k] != '0)) begin
                if (stage_rd[k] == hz.ex_rs1) fwd1 = SEL_W'(k + 1);
                if (stage_rd[k] == hz.ex_rs2) fwd2 = SEL_W'(k + 1);
                if (stage_rd[k] == hz.id_rs1) idf1 = SEL_W'(k + 1);
                if (stage_rd[k] == hz.id_rs2) idf2 = SEL_W'(k + 1);
            end
        end
        // A load in EX_MEM has no data yet. An older stage must not stand in
        // for it, so the branch waits (it is stalled below) with select 0.
        if (!hz.id_branch || (hz.stage0_load && (idf1 == SEL_W'(1)))) idf1 = '0;
        if (!hz.id_branch || (hz.stage0_load && (idf2 == SEL_W'(1)))) idf2 = '0;
    end

    // ---------------- scoreboard state ----------------
    logic [MC_SLOTS-1:0] slot_valid_q, slot_valid_d;
    logic [REG_AW-1:0]   slot_rd_q  [MC_SLOTS];
    logic [REG_AW-1:0]   slot_rd_d  [MC_SLOTS];
    logic [MC_LAT_W-1:0] slot_cnt_q [MC_SLOTS];
    logic [MC_LAT_W-1:0] slot_cnt_d [MC_SLOTS];

    logic                id_pending, waw, all_busy, done_any, placed;
    logic [MC_SLOTS-1:0] done_onehot;
    logic [REG_AW-1:0]   done_rd;

    always_comb begin
        id_pending  = 1'b0;
        waw         = 1'b0;
        all_busy    = 1'b1;
        done_any    = 1'b0;
        done_onehot = '0;
        done_rd     = '0;
        for (int s = 0; s < MC_SLOTS; s++) begin
            if (slot_valid_q[s]) begin
                if (reads_reg(slot_rd_q[s], hz.id_rs1, hz.id_rs2,
                              hz.id_use_rs1, hz.id_use_rs2)) id_pending = 1'b1;
                if (slot_rd_q[s] == hz.mc_rd) waw = 1'b1;
                // Only the lowest finishing slot reports in a cycle.
                if ((slot_cnt_q[s] == MC_LAT_W'(1)) && !done_any) begin
                    done_any       = 1'b1;
                    done_onehot[s] = 1'b1;
                    done_rd        = slot_rd_q[s];
                end
            end else begin
                all_busy = 1'b0;
            end
        end
    end

    // ---------------- stall causes ----------------
    logic ex_hit, s0_hit, cause_a, cause_b, cause_c, cause_d, cause_e;
    logic stall, mc_accept;

    assign ex_hit  = reads_reg(hz.ex_rd, hz.id_rs1, hz.id_rs2, hz.id_use_rs1, hz.id_use_rs2);
    assign s0_hit  = reads_reg(stage_rd[0], hz.id_rs1, hz.id_rs2, hz.id_use_rs1, hz.id_use_rs2);
    assign cause_a = hz.ex_load && ex_hit;
    assign cause_b = hz.id_branch && hz.ex_regWrite && ex_hit;
    assign cause_c = hz.id_branch && hz.stage0_load && s0_hit;
    assign cause_d = id_pending;
    // An issue with rd == x0 never takes a slot, so it can never block.
    assign cause_e = hz.mc_issue && (hz.mc_rd != '0) && (all_busy || waw);
    assign stall   = cause_a || cause_b || cause_c || cause_d || cause_e;

    assign mc_accept = hz.mc_issue && !stall && (hz.mc_rd != '0);

    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_rd_d    = slot_rd_q;
        slot_cnt_d   = slot_cnt_q;
        placed       = 1'b0;
        for (int s = 0; s < MC_SLOTS; s++) begin
            if (slot_valid_q[s]) begin
                if (slot_cnt_q[s] != MC_LAT_W'(1)) begin
                    slot_cnt_d[s] = slot_cnt_q[s] - MC_LAT_W'(1);
                end else if (done_onehot[s]) begin
                    slot_valid_d[s] = 1'b0;
                    slot_rd_d[s]    = '0;
                    slot_cnt_d[s]   = '0;
                end
                // A finished slot that is not reporting holds at count 1.
            end else if (mc_accept && !placed) begin
                // Free-slot search uses occupancy before the edge, so a slot
                // that empties at this edge is not reused until the next cycle.
                placed          = 1'b1;
                slot_valid_d[s] = 1'b1;
                slot_rd_d[s]    = hz.mc_rd;
                slot_cnt_d[s]   = (hz.mc_latency == '0) ? MC_LAT_W'(1) : hz.mc_latency;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_valid_q <= '0;
            for (int s = 0; s < MC_SLOTS; s++) begin
                slot_rd_q[s]  <= '0;
                slot_cnt_q[s] <= '0;
            end
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_rd_q    <= slot_rd_d;
            slot_cnt_q   <= slot_cnt_d;
        end
    end

    assign hz.forwardOp1    = fwd1;
    assign hz.forwardOp2    = fwd2;
    assign hz.ID_forwardOp1 = idf1;
    assign hz.ID_forwardOp2 = idf2;
    assign hz.stall         = stall;
    assign hz.nop           = stall;
    assign hz.mc_busy       = |slot_valid_q;
    assign hz.mc_done       = done_any;
    assign hz.mc_done_rd    = done_rd;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d, perf_mc_q, perf_mc_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_mc_d    = perf_mc_q;
        if (stall && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
        if ((cause_d || cause_e) && (perf_mc_q != '1)) perf_mc_d = perf_mc_q + 32'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_stall_q <= '0;
            perf_mc_q    <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_mc_q    <= perf_mc_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_mc_stalls    = perf_mc_q;
`endif
endmodule
